// File: rtl/c4_pkg.sv
// Connect-4 board geometry, sequencer state encoding and the landing-row search
// shared by the game core.
package c4_pkg;
    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int CELLS = 42;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef enum logic [2:0] {SELECT, FALL, COMMIT, CHECK, WIN, DRAW} seq_state_t;

    // Row 0 is the top, so the landing row is the largest empty row index.
    function automatic logic [2:0] landing_row(input board_t occ, input logic [2:0] col);
        logic [2:0] row;
        row = 3'd0;
        for (int r = 0; r < ROWS; r++) begin
            if (!occ[r][col]) row = 3'(r);
        end
        return row;
    endfunction
endpackage

// File: rtl/step_timer.sv
// Purpose: paces the falling-token animation; exists only when DROP_ANIM_EN is defined.
// Latency: tick is asserted on the last of every STEP_CYCLES enabled cycles.
// Backpressure: none; counts freely while enabled, clr restarts the count.
`ifdef DROP_ANIM_EN
module step_timer #(
    parameter int STEP_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(STEP_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule
`endif

// File: rtl/turn_sequencer.sv
// Purpose: per-move Connect-4 control FSM (cursor, drop animation under DROP_ANIM_EN, commit, win check).
// Latency: cursor +1 cycle; confirm-to-commit (land_row+1)*STEP_CYCLES cycles, or 1 cycle without DROP_ANIM_EN.
// Backpressure: win_req held until win_ack; buttons ignored outside SELECT.
module turn_sequencer
    import c4_pkg::*;
#(
    parameter int STEP_CYCLES = 8,
    parameter int START_COL   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       confirm,
    input  logic       win_ack,
    input  logic       win_found,
    output board_t     board0,
    output board_t     board1,
    output logic [2:0] position,
    output logic       current_player,
    output logic       fall_valid,
    output logic [2:0] fall_row,
    output logic       reject,
    output logic       win_req,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);
    if (STEP_CYCLES < 1 || START_COL < 0 || START_COL >= COLS) begin : g_bad_params
        $error("turn_sequencer: STEP_CYCLES must be >= 1 and START_COL in 0..6");
    end

    seq_state_t state_q, state_d;
    board_t     board0_q, board0_d, board1_q, board1_d;
    logic [2:0] pos_q, pos_d;
    logic       player_q, player_d;
    logic [5:0] move_cnt_q, move_cnt_d;
    logic [2:0] land_row_q, land_row_d;
    logic       reject_q, reject_d;
    logic       win_req_q, win_req_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       draw_q, draw_d;

    board_t     occ;
    logic       col_full;
    logic [2:0] land_row;

    assign occ      = board0_q | board1_q;
    assign col_full = occ[0][pos_q];
    assign land_row = landing_row(occ, pos_q);

`ifdef DROP_ANIM_EN
    logic [2:0] fall_row_q, fall_row_d;
    logic       fall_valid_q, fall_valid_d;
    logic       timer_clr;
    logic       step_tick;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (state_q == FALL),
        .tick  (step_tick)
    );

    assign fall_valid = fall_valid_q;
    assign fall_row   = fall_row_q;
`else
    assign fall_valid = 1'b0;
    assign fall_row   = 3'd0;
`endif

    always_comb begin
        state_d     = state_q;
        board0_d    = board0_q;
        board1_d    = board1_q;
        pos_d       = pos_q;
        player_d    = player_q;
        move_cnt_d  = move_cnt_q;
        land_row_d  = land_row_q;
        reject_d    = 1'b0;
        win_req_d   = win_req_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        draw_d      = draw_q;
`ifdef DROP_ANIM_EN
        fall_row_d   = fall_row_q;
        fall_valid_d = fall_valid_q;
        timer_clr    = 1'b0;
`endif
        case (state_q)
            SELECT: begin
                if (confirm) begin
                    if (col_full) begin
                        reject_d = 1'b1;
                    end else begin
                        land_row_d = land_row;
`ifdef DROP_ANIM_EN
                        state_d      = FALL;
                        fall_row_d   = 3'd0;
                        fall_valid_d = 1'b1;
                        timer_clr    = 1'b1;
`else
                        state_d = COMMIT;
`endif
                    end
                end else if (left && !right) begin
                    if (pos_q != 3'd0) pos_d = pos_q - 3'd1;
                end else if (right && !left) begin
                    if (pos_q != 3'(COLS - 1)) pos_d = pos_q + 3'd1;
                end
            end
            FALL: begin
`ifdef DROP_ANIM_EN
                if (step_tick) begin
                    if (fall_row_q == land_row_q) begin
                        state_d      = COMMIT;
                        fall_valid_d = 1'b0;
                    end else begin
                        fall_row_d = fall_row_q + 3'd1;
                    end
                end
`else
                state_d = COMMIT;
`endif
            end
            COMMIT: begin
                if (player_q) board1_d[land_row_q][pos_q] = 1'b1;
                else          board0_d[land_row_q][pos_q] = 1'b1;
                move_cnt_d = move_cnt_q + 6'd1;
                win_req_d  = 1'b1;
                state_d    = CHECK;
            end
            CHECK: begin
                if (win_ack) begin
                    win_req_d = 1'b0;
                    if (win_found) begin
                        state_d     = WIN;
                        game_over_d = 1'b1;
                        winner_d    = player_q;
                    end else if (move_cnt_q == 6'(CELLS)) begin
                        state_d     = DRAW;
                        game_over_d = 1'b1;
                        draw_d      = 1'b1;
                    end else begin
                        state_d  = SELECT;
                        player_d = ~player_q;
                        pos_d    = 3'(START_COL);
                    end
                end
            end
            WIN, DRAW: begin
            end
            default: state_d = SELECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SELECT;
            board0_q    <= '0;
            board1_q    <= '0;
            pos_q       <= 3'(START_COL);
            player_q    <= 1'b0;
            move_cnt_q  <= 6'd0;
            land_row_q  <= 3'd0;
            reject_q    <= 1'b0;
            win_req_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
`ifdef DROP_ANIM_EN
            fall_row_q   <= 3'd0;
            fall_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            board0_q    <= board0_d;
            board1_q    <= board1_d;
            pos_q       <= pos_d;
            player_q    <= player_d;
            move_cnt_q  <= move_cnt_d;
            land_row_q  <= land_row_d;
            reject_q    <= reject_d;
            win_req_q   <= win_req_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            draw_q      <= draw_d;
`ifdef DROP_ANIM_EN
            fall_row_q   <= fall_row_d;
            fall_valid_q <= fall_valid_d;
`endif
        end
    end

    assign board0         = board0_q;
    assign board1         = board1_q;
    assign position       = pos_q;
    assign current_player = player_q;
    assign reject         = reject_q;
    assign win_req        = win_req_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;
    assign draw           = draw_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: cursor, single move timing, reject, wins, draw and async reset,
// with expected boards kept from per-column fill heights.
module tb_turn_sequencer;
    localparam int STEP  = 8;
    localparam int START = 3;

    logic            clk = 1'b0;
    logic            reset, left, right, confirm, win_ack, win_found;
    logic [5:0][6:0] board0, board1;
    logic [2:0]      position, fall_row;
    logic            current_player, fall_valid, reject, win_req, game_over, winner, draw;

    int checks = 0;
    int passes = 0;
    int fv_seen = 0;

    logic [5:0][6:0] exp_b0, exp_b1;
    int height [7];
    int exp_pos, exp_player, moves;

    turn_sequencer #(.STEP_CYCLES(STEP), .START_COL(START)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .confirm(confirm),
        .win_ack(win_ack), .win_found(win_found), .board0(board0), .board1(board1),
        .position(position), .current_player(current_player), .fall_valid(fall_valid),
        .fall_row(fall_row), .reject(reject), .win_req(win_req), .game_over(game_over),
        .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (fall_valid === 1'b1) fv_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        left = 0; right = 0; confirm = 0; win_ack = 0; win_found = 0;
        reset = 1;
        step(); step();
        reset = 0;
        step();
        exp_b0 = '0; exp_b1 = '0; exp_pos = START; exp_player = 0; moves = 0;
        for (int i = 0; i < 7; i++) height[i] = 0;
    endtask

    task automatic move_cursor(input int col);
        while (exp_pos > col) begin left = 1; step(); left = 0; exp_pos--; end
        while (exp_pos < col) begin right = 1; step(); right = 0; exp_pos++; end
    endtask

    task automatic drop(input int col, input bit found, input bit do_ack);
        int n;
        move_cursor(col);
        confirm = 1; step(); confirm = 0;
        n = 0;
        while (win_req !== 1'b1 && n < 200) begin step(); n++; end
        checks++; if (win_req !== 1'b1) $display("FAIL drop_win_req col=%0d got %b want 1", col, win_req); else passes++;
        if (exp_player == 0) exp_b0[5 - height[col]][col] = 1'b1;
        else                 exp_b1[5 - height[col]][col] = 1'b1;
        height[col]++;
        moves++;
        checks++;
        if (board0 !== exp_b0 || board1 !== exp_b1)
            $display("FAIL drop_board move=%0d col=%0d got %h/%h want %h/%h", moves, col, board0, board1, exp_b0, exp_b1);
        else passes++;
        if (do_ack) begin
            win_ack = 1; win_found = found; step(); win_ack = 0; win_found = 0;
            if (!found && moves < 42) begin exp_player ^= 1; exp_pos = START; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (position !== 3'(START)) $display("FAIL reset_position got %0d want %0d", position, START); else passes++;
        checks++; if (current_player !== 1'b0) $display("FAIL reset_player got %b want 0", current_player); else passes++;
        checks++; if (board0 !== '0 || board1 !== '0) $display("FAIL reset_boards got %h/%h want 0/0", board0, board1); else passes++;
        checks++; if ({fall_valid, reject, win_req} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {fall_valid, reject, win_req}); else passes++;
        checks++; if ({game_over, winner, draw} !== 3'b000) $display("FAIL reset_flags got %b want 000", {game_over, winner, draw}); else passes++;
        checks++; if (fall_row !== 3'd0) $display("FAIL reset_fall_row got %0d want 0", fall_row); else passes++;
    endtask

    task automatic test_cursor();
        int exp_r [7];
        exp_r = '{4, 5, 6, 6, 6, 6, 6};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            right = 1; step(); right = 0;
            checks++; if (position !== 3'(exp_r[i])) $display("FAIL cursor_right%0d got %0d want %0d", i, position, exp_r[i]); else passes++;
        end
        left = 1; right = 1; step(); left = 0; right = 0;
        checks++; if (position !== 3'd6) $display("FAIL cursor_both got %0d want 6", position); else passes++;
        win_ack = 1; win_found = 1; step(); win_ack = 0; win_found = 0;
        checks++; if (game_over !== 1'b0 || win_req !== 1'b0) $display("FAIL stray_ack got go=%b req=%b want 0/0", game_over, win_req); else passes++;
        for (int i = 0; i < 7; i++) begin left = 1; step(); left = 0; end
        checks++; if (position !== 3'd0) $display("FAIL cursor_left_sat got %0d want 0", position); else passes++;
    endtask

    task automatic test_single_move();
        do_reset();
        confirm = 1; right = 1; step(); confirm = 0; right = 0;
        checks++; if (position !== 3'd3) $display("FAIL confirm_priority got %0d want 3", position); else passes++;
`ifdef DROP_ANIM_EN
        for (int k = 0; k < 6 * STEP; k++) begin
            checks++;
            if (fall_valid !== 1'b1 || fall_row !== 3'(k / STEP))
                $display("FAIL fall_trace cycle=%0d got v=%b row=%0d want v=1 row=%0d", k, fall_valid, fall_row, k / STEP);
            else passes++;
            step();
        end
`endif
        checks++; if (fall_valid !== 1'b0) $display("FAIL commit_fall_valid got %b want 0", fall_valid); else passes++;
        checks++; if (board0 !== '0 || win_req !== 1'b0) $display("FAIL commit_early got b0=%h req=%b want 0/0", board0, win_req); else passes++;
        step();
        exp_b0 = '0; exp_b0[5][3] = 1'b1;
        checks++; if (board0 !== exp_b0 || board1 !== '0) $display("FAIL move_board got %h/%h want %h/0", board0, board1, exp_b0); else passes++;
        checks++; if (win_req !== 1'b1) $display("FAIL move_win_req got %b want 1", win_req); else passes++;
        step(); step();
        checks++; if (win_req !== 1'b1) $display("FAIL win_req_hold got %b want 1", win_req); else passes++;
        win_ack = 1; win_found = 0; step(); win_ack = 0;
        checks++; if (win_req !== 1'b0) $display("FAIL win_req_drop got %b want 0", win_req); else passes++;
        checks++; if (current_player !== 1'b1) $display("FAIL toggle_player got %b want 1", current_player); else passes++;
        checks++; if (position !== 3'(START)) $display("FAIL pos_restore got %0d want %0d", position, START); else passes++;
        checks++; if (game_over !== 1'b0) $display("FAIL move_game_over got %b want 0", game_over); else passes++;
`ifndef DROP_ANIM_EN
        checks++; if (fv_seen !== 0) $display("FAIL fall_valid_tied got %0d cycles want 0", fv_seen); else passes++;
`endif
    endtask

    task automatic test_reject();
        do_reset();
        for (int i = 0; i < 6; i++) drop(0, 1'b0, 1'b1);
        move_cursor(0);
        confirm = 1; step(); confirm = 0;
        checks++; if (reject !== 1'b1) $display("FAIL reject_pulse got %b want 1", reject); else passes++;
        checks++; if (board0 !== exp_b0 || board1 !== exp_b1) $display("FAIL reject_boards got %h/%h want %h/%h", board0, board1, exp_b0, exp_b1); else passes++;
        step();
        checks++; if (reject !== 1'b0) $display("FAIL reject_one_cycle got %b want 0", reject); else passes++;
        checks++; if (win_req !== 1'b0 || current_player !== 1'b0) $display("FAIL reject_state got req=%b pl=%b want 0/0", win_req, current_player); else passes++;
        right = 1; step(); right = 0;
        checks++; if (position !== 3'd1) $display("FAIL reject_select got %0d want 1", position); else passes++;
    endtask

    task automatic test_win();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drop(c, 1'b0, 1'b1);
            drop(c, 1'b0, 1'b1);
        end
        drop(3, 1'b1, 1'b1);
        checks++; if (game_over !== 1'b1 || draw !== 1'b0) $display("FAIL win_flags got go=%b draw=%b want 1/0", game_over, draw); else passes++;
        checks++; if (winner !== 1'b0) $display("FAIL win_winner0 got %b want 0", winner); else passes++;
        checks++; if (win_req !== 1'b0) $display("FAIL win_req_after got %b want 0", win_req); else passes++;
        right = 1; step(); right = 0;
        confirm = 1; step(); confirm = 0;
        step(); step();
        checks++; if (position !== 3'd3) $display("FAIL win_buttons got pos %0d want 3", position); else passes++;
        checks++; if (board0 !== exp_b0 || board1 !== exp_b1 || win_req !== 1'b0) $display("FAIL win_frozen got %h/%h req=%b", board0, board1, win_req); else passes++;
        checks++; if (game_over !== 1'b1) $display("FAIL win_sticky got %b want 1", game_over); else passes++;
        do_reset();
        drop(0, 1'b0, 1'b1);
        drop(1, 1'b1, 1'b1);
        checks++; if (game_over !== 1'b1 || winner !== 1'b1) $display("FAIL win_winner1 got go=%b w=%b want 1/1", game_over, winner); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drop(2, 1'b0, 1'b1);
        drop(4, 1'b0, 1'b0);
        reset = 1; #1;
        checks++; if (board0 !== '0 || board1 !== '0) $display("FAIL rst_check_boards got %h/%h want 0/0", board0, board1); else passes++;
        checks++; if (win_req !== 1'b0 || current_player !== 1'b0) $display("FAIL rst_check_req got req=%b pl=%b want 0/0", win_req, current_player); else passes++;
        checks++; if (position !== 3'(START)) $display("FAIL rst_check_pos got %0d want %0d", position, START); else passes++;
        step(); reset = 0; step();
`ifdef DROP_ANIM_EN
        do_reset();
        drop(2, 1'b0, 1'b1);
        confirm = 1; step(); confirm = 0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (fall_valid !== 1'b1) $display("FAIL rst_fall_active got %b want 1", fall_valid); else passes++;
        reset = 1; #1;
        checks++; if (fall_valid !== 1'b0 || board0 !== '0) $display("FAIL rst_fall got v=%b b0=%h want 0/0", fall_valid, board0); else passes++;
        checks++; if (position !== 3'(START)) $display("FAIL rst_fall_pos got %0d want %0d", position, START); else passes++;
        step(); reset = 0; step();
`endif
    endtask

    task automatic test_draw();
        do_reset();
        for (int i = 0; i < 42; i++) begin
            drop(i / 6, 1'b0, 1'b1);
            if (i == 40) begin
                checks++; if (game_over !== 1'b0 || draw !== 1'b0) $display("FAIL draw_early got go=%b d=%b want 0/0", game_over, draw); else passes++;
            end
        end
        checks++; if (draw !== 1'b1 || game_over !== 1'b1) $display("FAIL draw_flags got go=%b d=%b want 1/1", game_over, draw); else passes++;
        checks++; if ((board0 | board1) !== {42{1'b1}} || (board0 & board1) !== '0) $display("FAIL draw_full got %h/%h", board0, board1); else passes++;
        checks++; if (board0 !== exp_b0) $display("FAIL draw_board0 got %h want %h", board0, exp_b0); else passes++;
    endtask

    initial begin
        reset = 1; left = 0; right = 0; confirm = 0; win_ack = 0; win_found = 0;
        test_reset();
        test_cursor();
        test_single_move();
        test_reject();
        test_win();
        test_reset_mid();
        test_draw();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Per-move control FSM for the Connect-4 game core:
- Owns the cursor column and the current player.
- Accepts a confirm, finds the landing row, animates the falling token and commits it into the two player boards.
- Hands the updated boards to the external win checker over a req/ack handshake.
- Alternates turns, or ends the game on a win or a full board.

Sits between the debounced/edge-detected button pulses and the LED mapping logic.

## Interface
Parameters:
- STEP_CYCLES, 8, clock cycles each falling-token row is displayed (≥1)
- START_COL, 3, cursor column after reset and after each committed move (0..6)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset; one clock domain (clk)
- left, right, confirm  input  1 each  single-cycle button pulses, already synchronised
- win_ack  input  1  win checker done; valid one cycle
- win_found  input  1  qualified by win_ack; current player has four in a row
- board0, board1  output  [5:0][6:0]  player-0 / player-1 occupancy, [row][col], row 0 top, row 5 bottom
- position  output  3  cursor column 0..6
- current_player  output  1  player whose move it is
- fall_valid  output  1  falling token shown this cycle
- fall_row  output  3  row of falling token (column = position)
- reject  output  1  one-cycle pulse: confirm on full column
- win_req  output  1  held high in CHECK until win_ack
- game_over, winner, draw  output  1 each  sticky end-of-game flags; winner valid when game_over & !draw

## Operation
States:
- SELECT
  - left: position−1, saturating at 0.
  - right: position+1, saturating at 6.
  - left & right together: no move.
  - confirm has priority over left/right in the same cycle.
  - Confirm on an occupied row 0 (board0|board1 at position) → reject pulse, stay in SELECT.
  - Otherwise latch land_row = highest empty row in the column → FALL.
- FALL
  - fall_valid=1, fall_row starts at 0.
  - fall_row increments after each STEP_CYCLES cycles.
  - Leave when fall_row==land_row and its STEP_CYCLES have elapsed → COMMIT.
  - Buttons ignored.
- COMMIT: one cycle; set board{current_player}[land_row][position]; move_count+1 → CHECK.
- CHECK
  - win_req=1.
  - On win_ack & win_found → WIN.
  - On win_ack & !win_found & move_count==42 → DRAW.
  - On win_ack otherwise → toggle current_player, position=START_COL → SELECT.
- WIN: game_over=1, winner=current_player. Terminal until reset.
- DRAW: game_over=1, draw=1. Terminal until reset.

Invariants and rules:
- Boards never have both bits set at the same cell.
- move_count is 6 bits.
- Buttons and win_ack are ignored outside the states that use them.

## Timing
Reset values:
- state=SELECT, boards all 0, position=START_COL, current_player=0, move_count=0.
- All flags and pulses are 0.

Latency:
- Cursor update is visible the cycle after the pulse.
- FALL lasts (land_row+1)·STEP_CYCLES cycles.
- The board bit is visible the cycle after COMMIT; win_req rises the same cycle.
- win_ack may arrive on the first CHECK cycle (combinational checker) or any later cycle.
- After win_ack, the new player is in SELECT the next cycle.

Other timing rules:
- Reset mid-FALL or mid-CHECK aborts immediately; the uncommitted token is lost.
- win_req drops the cycle after ack.

## Configuration
DROP_ANIM_EN:
- Defined: FALL state and step timer exist as described.
- Undefined:
  - SELECT goes straight to COMMIT.
  - fall_valid is tied 0; fall_row is tied 0.
  - STEP_CYCLES is unused.
  - Commit occurs the cycle after confirm.

## Structure
- Package c4_pkg:
  - ROWS=6, COLS=7, CELLS=42.
  - board_t ([ROWS-1:0][COLS-1:0]).
  - seq_state_t enum {SELECT, FALL, COMMIT, CHECK, WIN, DRAW}.
- Sub-module step_timer: counts 0..STEP_CYCLES−1, emits a tick pulse on wrap, cleared on FALL entry.
  - Compiled only under DROP_ANIM_EN.
- Landing-row search is combinational inside turn_sequencer.

## Test plan
- Reset, 7 right pulses → position 4,5,6,6,6,6,6 (saturates).
- Column 3 empty, confirm, STEP_CYCLES=8:
  - fall_row steps 0..5, 8 cycles each.
  - Then board0[5][3]=1; win_req rises; ack with win_found=0.
  - Then current_player=1, position=3.
- Fill column 0 with six alternating moves, seventh confirm → reject=1 for one cycle, boards unchanged, still SELECT.
- Player 0 drops in cols 0,1,2,3 (row 5), player 1 in row 4; fourth player-0 ack with win_found=1 → game_over=1, winner=0; further buttons ignored.
- Assert reset during FALL → boards 0, position=START_COL, fall_valid=0 immediately.
- 42 non-winning moves with ack win_found=0 → draw=1, game_over=1 after the 42nd ack.
- Without DROP_ANIM_EN: confirm → board bit set 2 cycles later, fall_valid never 1.
